// File: rtl/img_count_pkg.sv
// -----------------------------------------------------------------------------
// img_count_pkg
// Shared definitions for the image-count bank: snapshot FSM state encoding and
// default configuration constants (channel count, counter width, channel ids).
// Build option: define IMG_CNT_SAT_EN to make the per-channel counters saturate
// instead of wrap (see img_channel_counter).
// -----------------------------------------------------------------------------
package img_count_pkg;

  localparam int NUM_CH_DEF = 2;
  localparam int CNT_W_DEF  = 16;
  localparam int CH_SCIENCE = 0;
  localparam int CH_NAV     = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PRESENT = 2'd2
  } flush_state_e;

endpackage

// File: rtl/img_channel_counter.sv
// -----------------------------------------------------------------------------
// img_channel_counter
// One image-count channel: a CNT_W-bit up/down counter driven by add/remove
// pulses, with a sticky overflow/underflow flag.
// Build option IMG_CNT_SAT_EN: defined -> saturate at all-ones / zero,
// undefined -> wrap modulo 2^CNT_W. Either way the attempt sets ovf.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset
//   add     in   image stored this cycle
//   remove  in   image erased this cycle
//   clear   in   synchronous zeroing of count and ovf (wins over add/remove)
//   count   out  current count
//   ovf     out  sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module img_channel_counter
  import img_count_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             add,
  input  logic             remove,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] FULL = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = ZERO;
      ovf_d   = 1'b0;
    end else if (add && !remove) begin
      if (count_q == FULL) begin
        ovf_d = 1'b1;
`ifdef IMG_CNT_SAT_EN
        count_d = FULL;
`else
        count_d = ZERO;
`endif
      end else begin
        count_d = count_q + ONE;
      end
    end else if (remove && !add) begin
      if (count_q == ZERO) begin
        ovf_d = 1'b1;
`ifdef IMG_CNT_SAT_EN
        count_d = ZERO;
`else
        count_d = FULL;
`endif
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= ZERO;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/img_count_bank.sv
// -----------------------------------------------------------------------------
// img_count_bank
// Bank of NUM_CH image counters (ch0 science, ch1 nav) plus a snapshot readout
// path: a flush request captures all counters into out_numimg_reg and presents
// it with a valid/ready handshake. Requests arriving while a snapshot is in
// flight coalesce into one pending request served right after the handshake.
// Build option IMG_CNT_SAT_EN selects saturating counters (default wraps).
//
// Ports:
//   clk                    in   clock, rising edge
//   reset                  in   asynchronous active-high reset
//   img_added[NUM_CH]      in   per-channel add pulse
//   img_removed[NUM_CH]    in   per-channel remove pulse
//   clear_counts           in   zero all counters and ovf flags
//   start_flush_numimg_reg in   snapshot request pulse
//   out_ready              in   consumer accepts snapshot
//   out_numimg_reg         out  snapshot, channel k at [k*CNT_W +: CNT_W]
//   out_valid_numimg_reg   out  snapshot valid
//   out_ovf[NUM_CH]        out  sticky per-channel overflow/underflow
//   busy                   out  snapshot capture/presentation in progress
// -----------------------------------------------------------------------------
module img_count_bank
  import img_count_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       img_added,
  input  logic [NUM_CH-1:0]       img_removed,
  input  logic                    clear_counts,
  input  logic                    start_flush_numimg_reg,
  input  logic                    out_ready,
  output logic [NUM_CH*CNT_W-1:0] out_numimg_reg,
  output logic                    out_valid_numimg_reg,
  output logic [NUM_CH-1:0]       out_ovf,
  output logic                    busy
);

  logic [NUM_CH*CNT_W-1:0] counts;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    img_channel_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .add    (img_added[g]),
      .remove (img_removed[g]),
      .clear  (clear_counts),
      .count  (counts[g*CNT_W +: CNT_W]),
      .ovf    (out_ovf[g])
    );
  end

  flush_state_e            state_q, state_d;
  logic                    pend_q, pend_d;
  logic [NUM_CH*CNT_W-1:0] snap_q, snap_d;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    unique case (state_q)
      IDLE: begin
        if (start_flush_numimg_reg) state_d = CAPTURE;
      end
      CAPTURE: begin
        // Counter registers as they stand now; this cycle's pulses land after.
        snap_d  = counts;
        state_d = PRESENT;
        if (start_flush_numimg_reg) pend_d = 1'b1;
      end
      PRESENT: begin
        if (out_ready) begin
          // A request arriving on the accept cycle is treated as pending.
          if (pend_q || start_flush_numimg_reg) begin
            state_d = CAPTURE;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (start_flush_numimg_reg) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
    end
  end

  assign out_numimg_reg       = snap_q;
  assign out_valid_numimg_reg = (state_q == PRESENT);
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_img_count_bank.sv
module tb_img_count_bank;

  localparam int NCH  = 2;
  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   img_added, img_removed;
  logic             clear_counts, start_flush_numimg_reg, out_ready;
  logic [NCH*CW-1:0] out_numimg_reg;
  logic             out_valid_numimg_reg;
  logic [NCH-1:0]   out_ovf;
  logic             busy;

  img_count_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .img_added              (img_added),
    .img_removed            (img_removed),
    .clear_counts           (clear_counts),
    .start_flush_numimg_reg (start_flush_numimg_reg),
    .out_ready              (out_ready),
    .out_numimg_reg         (out_numimg_reg),
    .out_valid_numimg_reg   (out_valid_numimg_reg),
    .out_ovf                (out_ovf),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: counts as plain integers, snapshot readout described as
  // "a capture is scheduled", "a snapshot is on offer", "one more is owed".
  int               m_cnt [NCH];
  logic [NCH-1:0]   m_ovf;
  logic [NCH*CW-1:0] m_snap;
  logic             m_valid;
  logic             m_cap;
  logic             m_pend;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
    m_ovf = '0; m_snap = '0; m_valid = 1'b0; m_cap = 1'b0; m_pend = 1'b0;
  endtask

  function automatic logic [NCH*CW-1:0] pack_counts();
    logic [NCH*CW-1:0] p;
    p = '0;
    for (int k = 0; k < NCH; k++) p[k*CW +: CW] = m_cnt[k][CW-1:0];
    return p;
  endfunction

  task automatic model_step();
    logic was_cap, was_val;
    if (reset) begin
      model_reset();
      return;
    end
    was_cap = m_cap;
    was_val = m_valid;
    if (was_cap) begin
      m_snap  = pack_counts();
      m_valid = 1'b1;
      m_cap   = 1'b0;
      if (start_flush_numimg_reg) m_pend = 1'b1;
    end else if (was_val) begin
      if (out_ready) begin
        m_valid = 1'b0;
        if (m_pend || start_flush_numimg_reg) begin
          m_cap  = 1'b1;
          m_pend = 1'b0;
        end
      end else if (start_flush_numimg_reg) begin
        m_pend = 1'b1;
      end
    end else if (start_flush_numimg_reg) begin
      m_cap = 1'b1;
    end
    for (int k = 0; k < NCH; k++) begin
      int n;
      if (clear_counts) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end else begin
        n = m_cnt[k] + int'(img_added[k]) - int'(img_removed[k]);
        if (n > MAXV || n < 0) begin
          m_ovf[k] = 1'b1;
`ifdef IMG_CNT_SAT_EN
          n = (n < 0) ? 0 : MAXV;
`else
          n = (n < 0) ? n + MAXV + 1 : n - (MAXV + 1);
`endif
        end
        m_cnt[k] = n;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] a, input logic [NCH-1:0] r,
                       input logic c, input logic s, input logic rd);
    img_added = a; img_removed = r; clear_counts = c;
    start_flush_numimg_reg = s; out_ready = rd;
    tick();
  endtask

  // Request a snapshot and stop once it is on offer (out_ready held low).
  task automatic flush_read();
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [NCH-1:0]    add;
    logic [NCH-1:0]    rem;
    logic              clr;
    logic              start;
    logic              rdy;
    logic              exp_valid;
    logic              exp_busy;
    logic [NCH*CW-1:0] exp_out;
    logic [NCH-1:0]    exp_ovf;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    tbl[1]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    tbl[2]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00};
    tbl[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h32, 2'b00};
    tbl[5]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h32, 2'b00};
    tbl[6]  = '{2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h32, 2'b00};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h32, 2'b00};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31, 2'b00};
    tbl[9]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31, 2'b00};
    tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h31, 2'b00};

    reset = 1'b1;
    img_added = '0; img_removed = '0; clear_counts = 1'b0;
    start_flush_numimg_reg = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out",   32'(out_numimg_reg), 32'h0);
    chk("reset_valid", 32'(out_valid_numimg_reg), 32'h0);
    chk("reset_busy",  32'(busy), 32'h0);
    chk("reset_ovf",   32'(out_ovf), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 3 nav + 2 science adds, flush with ready, then a held-off second flush.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].add, tbl[i].rem, tbl[i].clr, tbl[i].start, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid_numimg_reg), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_busy", i),  32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_out", i),   32'(out_numimg_reg), 32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_ovf", i),   32'(out_ovf), 32'(tbl[i].exp_ovf));
    end

    // add+remove together holds the count
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    repeat (7) drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    flush_read();
    chk("addrem_cnt", 32'(out_numimg_reg[CW-1:0]), 32'd7);
    chk("addrem_ovf", 32'(out_ovf), 32'h0);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // 17 adds on nav into a 4-bit counter
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    repeat (17) drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    flush_read();
`ifdef IMG_CNT_SAT_EN
    chk("ovf_cnt1", 32'(out_numimg_reg[2*CW-1:CW]), 32'd15);
`else
    chk("ovf_cnt1", 32'(out_numimg_reg[2*CW-1:CW]), 32'd1);
`endif
    chk("ovf_flag", 32'(out_ovf), 32'b10);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // clear wins over add and drops the flag
    drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    flush_read();
    chk("clr_cnt", 32'(out_numimg_reg), 32'h0);
    chk("clr_ovf", 32'(out_ovf), 32'h0);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // backpressure with a coalesced second request
    repeat (3) drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    flush_read();
    drive(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      chk($sformatf("hold%0d_out", i), 32'(out_numimg_reg), 32'h03);
      chk($sformatf("hold%0d_valid", i), 32'(out_valid_numimg_reg), 32'h1);
    end
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("second_cap_valid", 32'(out_valid_numimg_reg), 32'h0);
    chk("second_cap_busy",  32'(busy), 32'h1);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("second_valid", 32'(out_valid_numimg_reg), 32'h1);
    chk("second_out",   32'(out_numimg_reg), 32'h04);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("second_done_busy", 32'(busy), 32'h0);

    // asynchronous reset while a snapshot is on offer
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    repeat (5) drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    flush_read();
    chk("pre_rst_out", 32'(out_numimg_reg), 32'h59);
    #2 reset = 1'b1;
    #1;
    chk("arst_out",   32'(out_numimg_reg), 32'h0);
    chk("arst_valid", 32'(out_valid_numimg_reg), 32'h0);
    chk("arst_busy",  32'(busy), 32'h0);
    chk("arst_ovf",   32'(out_ovf), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("post_rst_busy",  32'(busy), 32'h0);
    chk("post_rst_valid", 32'(out_valid_numimg_reg), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(NCH'($urandom), NCH'($urandom),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1));
      chk("rnd_valid", 32'(out_valid_numimg_reg), 32'(m_valid));
      chk("rnd_busy",  32'(busy), 32'(m_valid | m_cap));
      chk("rnd_out",   32'(out_numimg_reg), 32'(m_snap));
      chk("rnd_ovf",   32'(out_ovf), 32'(m_ovf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/img_count_bank.md
IMG_COUNT_BANK -- requirements
Module: img_count_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of image-type channels (ch0 = science, ch1 = nav); legal 1..8.
REQ-002 SHALL have parameter CNT_W, default 16, per-channel counter width; legal 4..32.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port img_added  input  NUM_CH  one-cycle pulse per channel, image stored.
REQ-006 SHALL have port img_removed  input  NUM_CH  one-cycle pulse per channel, image erased.
REQ-007 SHALL have port clear_counts  input  1  synchronous zeroing of all counters and flags.
REQ-008 SHALL have port start_flush_numimg_reg  input  1  pulse requesting a snapshot readout.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the snapshot.
REQ-010 SHALL have port out_numimg_reg  output  NUM_CH*CNT_W  snapshot; channel k at bits [k*CNT_W +: CNT_W].
REQ-011 SHALL have port out_valid_numimg_reg  output  1  snapshot valid.
REQ-012 SHALL have port out_ovf  output  NUM_CH  sticky per-channel overflow/underflow flag.
REQ-013 SHALL have port busy  output  1  high while a snapshot is pending.

Function
REQ-014 SHALL keep one CNT_W-bit counter per channel, updated every cycle from its add/remove pulses.
REQ-015 SHALL increment on add-only, decrement on remove-only, hold when both or neither are asserted in a cycle.
REQ-016 SHALL update all channels independently and concurrently in the same cycle.
REQ-017 SHALL give clear_counts priority over add/remove in the same cycle; out_ovf also cleared; pending snapshot unaffected.
REQ-018 SHALL implement FSM IDLE -> CAPTURE -> PRESENT -> IDLE.
REQ-019 IDLE: start_flush pulse moves to CAPTURE next cycle; otherwise stay.
REQ-020 CAPTURE: latch all counters into out_numimg_reg (values including that cycle's pending updates excluded, i.e. register values at CAPTURE edge); move to PRESENT.
REQ-021 PRESENT: out_valid_numimg_reg high, out_numimg_reg stable until out_ready sampled high; then IDLE.
REQ-022 Latency start_flush -> out_valid SHALL be exactly 2 cycles.
REQ-023 start_flush while busy SHALL set a single pending bit; on leaving PRESENT with pending set, go directly to CAPTURE and clear pending; further requests coalesce.
REQ-024 busy SHALL be high in CAPTURE and PRESENT, low in IDLE.
REQ-025 Counters SHALL keep counting during CAPTURE/PRESENT; snapshot unaffected.

Reset
REQ-026 reset high SHALL asynchronously force counters 0, out_numimg_reg 0, out_valid_numimg_reg 0, out_ovf 0, busy 0, pending 0, FSM IDLE.
REQ-027 reset mid-PRESENT SHALL drop the snapshot without handshake; release resumes in IDLE.

Configuration
REQ-028 Macro IMG_CNT_SAT_EN defined: counters saturate at 2^CNT_W-1 on add and at 0 on remove; attempted overflow/underflow sets out_ovf[k].
REQ-029 Macro IMG_CNT_SAT_EN undefined: counters wrap modulo 2^CNT_W; out_ovf[k] set on wrap in either direction.

Structure
REQ-030 Package img_count_pkg SHALL hold FSM state enum (IDLE, CAPTURE, PRESENT) and default constants NUM_CH_DEF=2, CNT_W_DEF=16, CH_SCIENCE=0, CH_NAV=1.
REQ-031 Per-channel counter SHALL be sub-module img_channel_counter (count, ovf, sat/wrap logic), instantiated NUM_CH times via generate.

Verification
REQ-032 3 nav adds, 2 science adds, flush, out_ready=1 -> out_valid at cycle +2 for 1 cycle, out_numimg_reg=0x0003_0002.
REQ-033 Simultaneous add+remove on ch0 for 5 cycles from count 7 -> count stays 7, out_ovf=0.
REQ-034 CNT_W=4, 17 adds on ch1: SAT_EN -> 15, ovf[1]=1; no SAT_EN -> 1, ovf[1]=1.
REQ-035 out_ready=0 for 10 cycles, second flush during PRESENT, ch0 add meanwhile -> first snapshot stable; after accept, second snapshot 2 cycles later shows new count.
REQ-036 reset asserted mid-PRESENT with counts 0x0005_0009 -> all outputs 0 immediately, no clk needed.
REQ-037 clear_counts and add same cycle on ch0 -> count 0, ovf cleared.
